rename_dispatch_queue: RTL
==========================

Name: rename_dispatch_queue

Overview:
- Parametrised successor of the single-entry rename/dispatch stage.
- Buffers up to DEPTH decoded micro-ops in a FIFO between decode and the reservation stations.
- Performs the RAT lookup and operand formation on the queue head, then steers the head to one of NUM_RS reservation-station targets.
- Keeps CSR serialization against the ROB head, forwarded-result writeback and ROB inhibit.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- NUM_RS, 3, number of dispatch targets (0 = exers, 1 = lsq, 2 = csr by default).
- CSR_RS, 2, target index that requires ROB-head serialization.
- ROBID_W, 7, ROB id width.
- SEL_W, 2, width of the target select; must be at least clog2(NUM_RS).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- decode_valid  in  1  micro-op offered
- decode_ready  out  1  queue accepts; transfer occurs when decode_valid & decode_ready
- decode_addr  in  30  PC[31:2]
- decode_rsop  in  5  RS opcode
- decode_robid  in  ROBID_W  ROB id
- decode_rd  in  6  dest reg; bit 5 = no destination
- decode_uses_rs1 / decode_uses_rs2 / decode_uses_imm / decode_uses_pc  in  1 each  operand source flags
- decode_rs_sel  in  SEL_W  dispatch target index
- decode_forward  in  1  result known at decode
- decode_inhibit  in  1  ROB ignores next wb
- decode_target  in  30  forwarded result[31:2]
- decode_rs1 / decode_rs2  in  5 each  source regs
- decode_imm  in  32  immediate
- rename_rs1 / rename_rs2  out  5 each  RAT read addresses (head entry)
- rat_rs1_valid / rat_rs2_valid  in  1 each  RAT operand is a value (1) or a tag (0)
- rat_rs1_tagval / rat_rs2_tagval  in  32 each  RAT value or tag
- rename_alloc  out  1  RAT tag allocation for the head entry
- rename_rd  out  6  dest register
- rename_robid  out  ROBID_W  ROB id
- rename_rs_write  out  NUM_RS  one-hot dispatch strobe
- rename_op  out  5  RS opcode
- rename_op1ready / rename_op2ready  out  1 each  operand ready flags
- rename_op1 / rename_op2  out  32 each  operand value or tag
- rename_imm  out  32  immediate
- rs_stall  in  NUM_RS  per-target backpressure
- csr_valid  in  1  CSR unit busy
- rename_wb_valid  out  1  forwarded writeback strobe
- rename_wb_result  out  30  forwarded result[31:2]
- rename_inhibit  out  1  ROB inhibit strobe
- rob_flush  in  1  flush
- rob_rename_head  in  ROBID_W  ROB head id
- rename_count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage:
  - Circular buffer with head/tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter.
  - Stored fields: every decode_* field except decode_valid.
  - rd is stored as decode_rd | {decode_forward,5'b0}.
- Enqueue:
  - decode_ready = (count != DEPTH), registered-equivalent; there is no full-bypass, so a full queue that dequeues this cycle still shows ready=0.
  - An entry written in cycle t is visible at the head no earlier than t+1 (no decode-to-dispatch bypass).
- Head eligibility:
  - hv = (count != 0).
  - Target s = head rs_sel.
  - blocked = rs_stall[s] | (s==CSR_RS & ((rob_rename_head != head robid) | csr_valid)).
  - fire = hv & ~blocked.
  - A CSR op dispatches in the same cycle its robid equals the ROB head and csr_valid=0.
- Dispatch outputs (combinational from the head entry):
  - rename_rs_write[s] = fire; all other bits are 0.
  - rename_alloc = fire & ~rd[5].
  - rename_wb_valid = fire & forward.
  - rename_inhibit = fire & inhibit.
  - rename_wb_result = target field; rename_rs1/rs2/op/robid/rd/imm = head fields.
  - Dequeue occurs on fire.
- Operand formation:
  - uses_rs1=0, uses_pc=0: op1 = (s==CSR_RS) ? {27'b0,rs1} : imm; op2 = 0; both ready.
  - uses_rs1=0, uses_pc=1: op1 = {addr,2'b00}; op2 = imm; both ready.
  - uses_rs1=1, uses_pc=0: op1 and op1ready come from the RAT rs1 port. Then:
    - if uses_rs2: op2 and op2ready come from the RAT rs2 port;
    - else if uses_imm: op2 = imm, op2ready = 1;
    - else op2 = 0, op2ready = 1.
  - uses_rs1=1, uses_pc=1: illegal; drive op1 = op2 = 0 and both ready = 1.
- Counter:
  - count' = count + enq − fire.
  - Simultaneous enq and fire leaves count unchanged; head and tail both advance.
- Flush:
  - rob_flush=1 clears count, head and tail on the next edge.
  - A same-cycle enqueue is dropped.
  - Dispatch strobes are still computed that cycle; the ROB discards them.
- Reset (rst=0, asynchronous):
  - count = 0, head = tail = 0.
  - Consequent outputs: decode_ready = 1; rename_rs_write, rename_alloc, rename_wb_valid and rename_inhibit = 0; rename_count = 0.
  - Deassertion takes effect at the next clk edge.
- Data fields are not reset.

Test Plan:
- Fill: rs_stall=0b001, 5 back-to-back exers ops with DEPTH=4 -> decode_ready drops after the 4th transfer, rename_count=4, no rename_rs_write.
- Drain: release rs_stall -> 4 consecutive cycles with rename_rs_write=0b001 in enqueue order; robid sequence preserved; count reaches 0.
- Wrap: stream 10 ops (rs_sel toggling 0/1) with a random stall on each target -> order preserved across pointer wrap; count is never above 4 or below 0.
- CSR serialization: CSR op robid=5, uses_rs1=0, rs1=5'd9, rob_rename_head=3 -> held. Then head=5 with csr_valid=1 -> held. Then csr_valid=0 -> rename_rs_write=0b100, op1=32'd9.
- Forward/inhibit: JAL-like op with forward=1, inhibit=1, rd=1, target=30'h100 -> on dispatch rename_rd=6'h21, rename_alloc=0, rename_wb_valid=1, rename_wb_result=30'h100, rename_inhibit=1.
- Flush/reset: 3 queued entries, then rob_flush asserted together with decode_valid -> count=0 next cycle and the new op is dropped. Asserting rst=0 mid-stream -> count=0 immediately without a clock edge.

Source files
------------

// File: rtl/rename_dispatch_queue.sv
// DEPTH-entry rename/dispatch FIFO: RAT lookup, operand formation and RS steering on the head entry.
// Latency: entry visible at head one cycle after enqueue; decode_ready low when full; head held while its target stalls.
module rename_dispatch_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_RS  = 3,
  parameter int CSR_RS  = 2,
  parameter int ROBID_W = 7,
  parameter int SEL_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         decode_valid,
  output logic                         decode_ready,
  input  logic [29:0]                  decode_addr,
  input  logic [4:0]                   decode_rsop,
  input  logic [ROBID_W-1:0]           decode_robid,
  input  logic [5:0]                   decode_rd,
  input  logic                         decode_uses_rs1,
  input  logic                         decode_uses_rs2,
  input  logic                         decode_uses_imm,
  input  logic                         decode_uses_pc,
  input  logic [SEL_W-1:0]             decode_rs_sel,
  input  logic                         decode_forward,
  input  logic                         decode_inhibit,
  input  logic [29:0]                  decode_target,
  input  logic [4:0]                   decode_rs1,
  input  logic [4:0]                   decode_rs2,
  input  logic [31:0]                  decode_imm,
  output logic [4:0]                   rename_rs1,
  output logic [4:0]                   rename_rs2,
  input  logic                         rat_rs1_valid,
  input  logic                         rat_rs2_valid,
  input  logic [31:0]                  rat_rs1_tagval,
  input  logic [31:0]                  rat_rs2_tagval,
  output logic                         rename_alloc,
  output logic [5:0]                   rename_rd,
  output logic [ROBID_W-1:0]           rename_robid,
  output logic [NUM_RS-1:0]            rename_rs_write,
  output logic [4:0]                   rename_op,
  output logic                         rename_op1ready,
  output logic                         rename_op2ready,
  output logic [31:0]                  rename_op1,
  output logic [31:0]                  rename_op2,
  output logic [31:0]                  rename_imm,
  input  logic [NUM_RS-1:0]            rs_stall,
  input  logic                         csr_valid,
  output logic                         rename_wb_valid,
  output logic [29:0]                  rename_wb_result,
  output logic                         rename_inhibit,
  input  logic                         rob_flush,
  input  logic [ROBID_W-1:0]           rob_rename_head,
  output logic [$clog2(DEPTH+1)-1:0]   rename_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [29:0]        addr;
    logic [4:0]         rsop;
    logic [ROBID_W-1:0] robid;
    logic [5:0]         rd;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               uses_imm;
    logic               uses_pc;
    logic [SEL_W-1:0]   rs_sel;
    logic               forward;
    logic               inhibit;
    logic [29:0]        target;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        imm;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             wr_dat;
  entry_t             head;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               hv, is_csr, stall_s, blocked, fire, enq;

  always_comb begin
    wr_dat          = '0;
    wr_dat.addr     = decode_addr;
    wr_dat.rsop     = decode_rsop;
    wr_dat.robid    = decode_robid;
    // A forwarded result never needs a RAT tag, so mark it as having no destination.
    wr_dat.rd       = decode_rd | {decode_forward, 5'b0};
    wr_dat.uses_rs1 = decode_uses_rs1;
    wr_dat.uses_rs2 = decode_uses_rs2;
    wr_dat.uses_imm = decode_uses_imm;
    wr_dat.uses_pc  = decode_uses_pc;
    wr_dat.rs_sel   = decode_rs_sel;
    wr_dat.forward  = decode_forward;
    wr_dat.inhibit  = decode_inhibit;
    wr_dat.target   = decode_target;
    wr_dat.rs1      = decode_rs1;
    wr_dat.rs2      = decode_rs2;
    wr_dat.imm      = decode_imm;
  end

  assign head         = mem_q[head_q];
  assign hv           = (count_q != '0);
  assign decode_ready = (count_q != CNT_W'(DEPTH));
  assign enq          = decode_valid & decode_ready & ~rob_flush;
  assign rename_count = count_q;

  // A select beyond NUM_RS sees no stall and raises no strobe, so it drains instead of wedging the queue.
  always_comb begin
    stall_s         = 1'b0;
    rename_rs_write = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (head.rs_sel == SEL_W'(i)) stall_s = rs_stall[i];
    end
    is_csr  = (head.rs_sel == SEL_W'(CSR_RS));
    blocked = stall_s | (is_csr & ((rob_rename_head != head.robid) | csr_valid));
    fire    = hv & ~blocked;
    for (int i = 0; i < NUM_RS; i++) begin
      rename_rs_write[i] = fire & (head.rs_sel == SEL_W'(i));
    end
  end

  assign rename_alloc     = fire & ~head.rd[5];
  assign rename_wb_valid  = fire & head.forward;
  assign rename_inhibit   = fire & head.inhibit;
  assign rename_wb_result = head.target;
  assign rename_rs1       = head.rs1;
  assign rename_rs2       = head.rs2;
  assign rename_op        = head.rsop;
  assign rename_robid     = head.robid;
  assign rename_rd        = head.rd;
  assign rename_imm       = head.imm;

  always_comb begin
    rename_op1      = '0;
    rename_op2      = '0;
    rename_op1ready = 1'b1;
    rename_op2ready = 1'b1;
    case ({head.uses_rs1, head.uses_pc})
      2'b00: rename_op1 = is_csr ? {27'b0, head.rs1} : head.imm;
      2'b01: begin
        rename_op1 = {head.addr, 2'b00};
        rename_op2 = head.imm;
      end
      2'b10: begin
        rename_op1      = rat_rs1_tagval;
        rename_op1ready = rat_rs1_valid;
        if (head.uses_rs2) begin
          rename_op2      = rat_rs2_tagval;
          rename_op2ready = rat_rs2_valid;
        end else if (head.uses_imm) begin
          rename_op2 = head.imm;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)  tail_d = tail_q + PTR_W'(1);
      if (fire) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= wr_dat;
  end

endmodule
